seq_multiplier: RTL
===================

# seq_multiplier

Iterative shift-add multiplier that computes the full 2*WIDTH-bit product of two WIDTH-bit operands over multiple clock cycles, one multiplier bit per cycle. It supports signed and unsigned operands, selected per operation. It is the area-lean, parametrised successor to the combinational array multiplier and sits on a valid/ready stream between an operand source and a result consumer. Each operation is self-contained, and operations are accepted one at a time.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a and b.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result; registered.

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch |a| and |b|: two's-complement magnitude when is_signed=1 and the MSB is set, else the raw value.
  - Latch neg = is_signed & (a[W-1] ^ b[W-1]).
  - Clear the accumulator and the counter, then go to BUSY.
- BUSY:
  - Each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; increment the counter.
  - After WIDTH iterations, load product = neg ? -acc : acc, truncated to 2*WIDTH bits. Go to DONE.
- DONE:
  - out_valid=1; product is held stable.
  - On out_ready, go to IDLE. out_valid drops on the same edge.
- Arithmetic:
  - The accumulator is 2*WIDTH bits. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which is representable as unsigned WIDTH bits.
  - The result is exact for all operand pairs; there is no overflow case.
- Unsigned mode matches a*b mod 2^(2*WIDTH). Signed mode matches the signed product in two's complement, 2*WIDTH bits.
- in_valid while not IDLE is ignored; the operands are not captured.
- is_signed=0 with MSB-set operands: the operands are treated as large unsigned values.

## Timing
- Reset values: product=0, out_valid=0, state=IDLE, so in_ready=1 during and after reset.
- Acceptance edge E. out_valid is high after edge E+WIDTH (WIDTH BUSY cycles).
- out_valid persists indefinitely while out_ready=0. product and out_valid change only at the output handshake edge or on reset.
- in_ready returns high the cycle after the output handshake.
  - No accept is possible on the handshake edge itself.
  - Minimum initiation interval is WIDTH+2 cycles.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-operation: immediate return to IDLE with product=0 and out_valid=0. The partial result is discarded and no output is produced.
- in_ready is combinational from state only; no path from in_valid.

## Configuration
- SEQ_MULT_EARLY_TERM_EN defined:
  - BUSY exits at the edge where the remaining shifted multiplier becomes zero after its addition, or after WIDTH iterations, whichever comes first.
  - Latency is max(1, position of the highest set bit of |b| + 1) cycles. |b|=0 takes 1 cycle.
- Not defined: latency is always exactly WIDTH cycles.
- Product values are identical in both builds.

## Test plan
- Unsigned max, WIDTH=8, is_signed=0:
  - a=8'hFF, b=8'hFF -> product=16'hFE01.
  - out_valid exactly 8 cycles after accept; in_ready=0 throughout.
- Signed corners, WIDTH=8, is_signed=1:
  - -128 * -128 -> 16'h4000.
  - -3 * 5 -> 16'hFFF1.
  - -128 * 127 -> 16'hC080.
  - 0 * -1 -> 16'h0000.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - Required: product stable, out_valid high, in_valid with new operands not accepted.
  - Release: one handshake, then in_ready=1 on the next cycle.
- Reset mid-operation:
  - Assert rst_n=0 at 3 cycles after accept of 9*7.
  - Required: product=0 and out_valid=0 immediately, in_ready=1.
  - A following 2*3 operation yields 16'h0006 normally.
- Early termination (build with SEQ_MULT_EARLY_TERM_EN):
  - b=1, a=200 -> product=200 after 1 cycle.
  - b=8'h80 unsigned -> 8 cycles.
  - b=0 -> product 0 after 1 cycle.
  - Without the macro, all three take 8 cycles with the same products.
- Random regression:
  - 10k random a, b, is_signed at WIDTH=8 and WIDTH=13, with random out_ready stalls.
  - Compare against the reference model; no mismatches.

Source files
------------

// File: rtl/seq_multiplier_if.sv
// Operand/result stream between an operand source, the seq_multiplier and a result consumer.
// master = source/consumer side, slave = multiplier side.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, signed or unsigned per operation.
// Optional SEQ_MULT_EARLY_TERM_EN: leave BUSY as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | shift-add iterations on operand magnitudes
// DONE  | product valid, held until out_ready
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic                 accept;
    logic                 last_iter;

    // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is correct as an unsigned value.
    assign mag_a   = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b   = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign accept  = bus.in_valid && (state == IDLE);
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = BUSY;
            BUSY:    if (last_iter)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            prod_q <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        end else if (state == BUSY) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
                prod_q <= neg ? -acc_sum : acc_sum;
            end
        end
    end

    assign bus.product = prod_q;
endmodule
